// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: four-entry video mode table and mode-switch sequencer for
// the HDMI timing generator. A switch waits for a frame edge, holds the
// generator in reset, loads the new timing, retunes the pixel PLL, settles
// and then releases the generator.
// Optional feature macro: VIDEO_MODE_CTRL_PLL_EN. When it is defined, the
// PLL handshake state is present. When it is undefined, LOAD goes straight
// to SETTLE, pll_req and pll_err stay low, and pll_done is ignored.
module video_mode_ctrl #(
    parameter logic [1:0] DEFAULT_MODE  = 2'd0,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         VS_TIMEOUT    = 2_000_000,
    parameter int         PLL_TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        mode_ack,
    output logic        mode_busy,
    output logic [1:0]  cur_mode,
    input  logic        tg_vs,
    output logic        tg_rst_n,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34,
    output logic [1:0]  pll_sel,
    output logic        pll_req,
    input  logic        pll_done,
    output logic        pll_err
);

    typedef struct packed {
        logic [11:0] h_total, h_sync, h_start, h_end;
        logic [11:0] v_total, v_sync, v_start, v_end;
    } timing_t;

    typedef struct packed {
        logic [11:0] q14, q24, q34;
    } quarter_t;

    typedef enum logic [2:0] {IDLE, WAIT_VS, LOAD, PLL, SETTLE, DONE} state_t;

    // Fixed mode table, fields in struct order.
    function automatic timing_t mode_entry(input logic [1:0] m);
        case (m)
            2'd0:    mode_entry = {12'd799,  12'd95,  12'd143, 12'd783,  12'd524,  12'd1, 12'd34, 12'd514};
            2'd1:    mode_entry = {12'd1649, 12'd39,  12'd259, 12'd1539, 12'd749,  12'd4, 12'd24, 12'd744};
            2'd2:    mode_entry = {12'd2199, 12'd43,  12'd189, 12'd2109, 12'd1124, 12'd4, 12'd40, 12'd1120};
            default: mode_entry = {12'd1055, 12'd127, 12'd215, 12'd1015, 12'd627,  12'd3, 12'd26, 12'd626};
        endcase
    endfunction

    // Quarter lines of the active region, 13-bit arithmetic truncated to 12 bits.
    function automatic quarter_t quarters(input timing_t t);
        logic [12:0] span, span3, s14, s24, s34;
        span  = {1'b0, t.v_end} - {1'b0, t.v_start};
        span3 = span + (span << 1);
        s14   = {1'b0, t.v_start} + (span >> 2);
        s24   = {1'b0, t.v_start} + (span >> 1);
        s34   = {1'b0, t.v_start} + (span3 >> 2);
        quarters = {s14[11:0], s24[11:0], s34[11:0]};
    endfunction

    localparam timing_t     DEFAULT_TIMING   = mode_entry(DEFAULT_MODE);
    localparam quarter_t    DEFAULT_QUARTERS = quarters(DEFAULT_TIMING);
    localparam logic [31:0] VS_LAST          = 32'(VS_TIMEOUT - 1);
    localparam logic [31:0] PLL_LAST         = 32'(PLL_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST      = 32'(SETTLE_CYCLES - 1);
`ifdef VIDEO_MODE_CTRL_PLL_EN
    localparam state_t BOOT_STATE = PLL;
    localparam state_t AFTER_LOAD = PLL;
`else
    localparam state_t BOOT_STATE = SETTLE;
    localparam state_t AFTER_LOAD = SETTLE;
`endif

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg;
    logic [1:0]  sel_reg, cur_mode_reg;
    timing_t     timing_reg;
    quarter_t    quarter_reg;
    logic        tg_rst_n_reg, mode_ack_reg, mode_busy_reg, boot_reg;
    logic        pll_req_reg, pll_err_reg, pll_started_reg;
    logic        vs_sync1_reg, vs_sync2_reg, vs_prev_reg;
    logic        frame_edge, pll_done_eff, pll_timeout;

`ifdef VIDEO_MODE_CTRL_PLL_EN
    assign pll_done_eff = pll_done;
    assign pll_req      = pll_req_reg;
    assign pll_err      = pll_err_reg;
`else
    logic unused_pll;
    assign unused_pll   = pll_done ^ pll_req_reg ^ pll_err_reg;
    assign pll_done_eff = 1'b0;
    assign pll_req      = 1'b0;
    assign pll_err      = 1'b0;
`endif

    // Frame edge: synchronized high-to-low transition of the sync pulse.
    assign frame_edge  = vs_prev_reg & ~vs_sync2_reg;
    assign pll_timeout = (state_reg == PLL) && pll_started_reg && !pll_done_eff && (cnt_reg == PLL_LAST);

    // State register; reset restarts the boot sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= BOOT_STATE;
        else          state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mode_req && !mode_ack_reg)
                         state_next = (mode_sel == cur_mode_reg) ? DONE : WAIT_VS;
            WAIT_VS: if (frame_edge || cnt_reg == VS_LAST) state_next = LOAD;
            LOAD:    state_next = AFTER_LOAD;
            PLL:     if (pll_started_reg && (pll_done_eff || cnt_reg == PLL_LAST)) state_next = SETTLE;
            SETTLE:  if (cnt_reg == SETTLE_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Two-flop synchronizer plus history flop for the generator vsync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_sync1_reg <= 1'b1;
            vs_sync2_reg <= 1'b1;
            vs_prev_reg  <= 1'b1;
        end else begin
            vs_sync1_reg <= tg_vs;
            vs_sync2_reg <= vs_sync1_reg;
            vs_prev_reg  <= vs_sync2_reg;
        end
    end

    // Registered outputs, per-state counter and handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg         <= '0;
            sel_reg         <= DEFAULT_MODE;
            cur_mode_reg    <= DEFAULT_MODE;
            timing_reg      <= DEFAULT_TIMING;
            quarter_reg     <= DEFAULT_QUARTERS;
            tg_rst_n_reg    <= 1'b0;
            mode_ack_reg    <= 1'b0;
            mode_busy_reg   <= 1'b1;
            boot_reg        <= 1'b1;
            pll_req_reg     <= 1'b0;
            pll_err_reg     <= 1'b0;
            pll_started_reg <= 1'b0;
        end else begin
            // The counter restarts on every state change; in PLL it starts
            // only once the reconfiguration strobe has gone out.
            cnt_reg <= (state_next != state_reg || (state_reg == PLL && !pll_started_reg))
                       ? '0 : cnt_reg + 32'd1;
            pll_started_reg <= (state_next == PLL);
            pll_req_reg     <= (state_next == PLL) && !pll_started_reg;
            if (pll_timeout) pll_err_reg <= 1'b1;
            // Completion pulse follows DONE; the boot pass stays silent.
            mode_ack_reg <= (state_reg == DONE) && !boot_reg;
            if (state_reg == IDLE && state_next != IDLE) begin
                sel_reg       <= mode_sel;
                mode_busy_reg <= 1'b1;
            end
            if (state_reg == DONE) begin
                mode_busy_reg <= 1'b0;
                boot_reg      <= 1'b0;
            end
            // Entering LOAD: hold the generator and retarget every timing field.
            if (state_reg == WAIT_VS && state_next == LOAD) begin
                tg_rst_n_reg <= 1'b0;
                timing_reg   <= mode_entry(sel_reg);
                quarter_reg  <= quarters(mode_entry(sel_reg));
                cur_mode_reg <= sel_reg;
            end
            if (state_next == DONE && state_reg != DONE) tg_rst_n_reg <= 1'b1;
        end
    end

    assign mode_ack    = mode_ack_reg;
    assign mode_busy   = mode_busy_reg;
    assign cur_mode    = cur_mode_reg;
    assign pll_sel     = cur_mode_reg;
    assign tg_rst_n    = tg_rst_n_reg;
    assign h_total     = timing_reg.h_total;
    assign h_sync      = timing_reg.h_sync;
    assign h_start     = timing_reg.h_start;
    assign h_end       = timing_reg.h_end;
    assign v_total     = timing_reg.v_total;
    assign v_sync      = timing_reg.v_sync;
    assign v_start     = timing_reg.v_start;
    assign v_end       = timing_reg.v_end;
    assign v_active_14 = quarter_reg.q14;
    assign v_active_24 = quarter_reg.q24;
    assign v_active_34 = quarter_reg.q34;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Testbench for video_mode_ctrl: directed and randomized mode switches checked
// against a cycle-level reference model built from the mode table and the
// switch-sequence timing rules.
module tb_video_mode_ctrl;

    localparam int SETTLE = 16;
    localparam int VS_TO  = 50;
    localparam int PLL_TO = 20;
`ifdef VIDEO_MODE_CTRL_PLL_EN
    localparam bit PLL_EN = 1'b1;
`else
    localparam bit PLL_EN = 1'b0;
`endif

    logic        clk, reset_n, mode_req, mode_ack, mode_busy, tg_vs, tg_rst_n;
    logic        pll_req, pll_done, pll_err;
    logic [1:0]  mode_sel, cur_mode, pll_sel;
    logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
    logic [11:0] v_active_14, v_active_24, v_active_34;

    video_mode_ctrl #(
        .DEFAULT_MODE(2'd0), .SETTLE_CYCLES(SETTLE), .VS_TIMEOUT(VS_TO), .PLL_TIMEOUT(PLL_TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode_req(mode_req), .mode_sel(mode_sel),
        .mode_ack(mode_ack), .mode_busy(mode_busy), .cur_mode(cur_mode),
        .tg_vs(tg_vs), .tg_rst_n(tg_rst_n),
        .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
        .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
        .v_active_14(v_active_14), .v_active_24(v_active_24), .v_active_34(v_active_34),
        .pll_sel(pll_sel), .pll_req(pll_req), .pll_done(pll_done), .pll_err(pll_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference mode table: h_total,h_sync,h_start,h_end,v_total,v_sync,v_start,v_end.
    int tbl [4][8] = '{
        '{799,  95,  143, 783,  524,  1, 34, 514},
        '{1649, 39,  259, 1539, 749,  4, 24, 744},
        '{2199, 43,  189, 2109, 1124, 4, 40, 1120},
        '{1055, 127, 215, 1015, 627,  3, 26, 626}
    };

    int checks = 0;
    int errors = 0;
    int exp_mode = 0;
    bit exp_err = 1'b0;
    int vs_cyc = -1, done_at = -1, pll_delay = 0, nreq = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // k-th quarter line of the active region of mode m.
    function automatic int quarter(input int m, input int k);
        int a;
        a = tbl[m][7] - tbl[m][6];
        return (tbl[m][6] + (k * a) / 4) % 4096;
    endfunction

    task automatic check_mode(input string ctx, input int m);
        check({ctx, " h_total"}, int'(h_total), tbl[m][0]);
        check({ctx, " h_sync"},  int'(h_sync),  tbl[m][1]);
        check({ctx, " h_start"}, int'(h_start), tbl[m][2]);
        check({ctx, " h_end"},   int'(h_end),   tbl[m][3]);
        check({ctx, " v_total"}, int'(v_total), tbl[m][4]);
        check({ctx, " v_sync"},  int'(v_sync),  tbl[m][5]);
        check({ctx, " v_start"}, int'(v_start), tbl[m][6]);
        check({ctx, " v_end"},   int'(v_end),   tbl[m][7]);
        check({ctx, " q14"}, int'(v_active_14), quarter(m, 1));
        check({ctx, " q24"}, int'(v_active_24), quarter(m, 2));
        check({ctx, " q34"}, int'(v_active_34), quarter(m, 3));
        check({ctx, " cur_mode"}, int'(cur_mode), m);
        check({ctx, " pll_sel"},  int'(pll_sel),  m);
    endtask

    task automatic check_reset_values(input string ctx);
        check({ctx, " tg_rst_n"},  int'(tg_rst_n),  0);
        check({ctx, " mode_ack"},  int'(mode_ack),  0);
        check({ctx, " pll_req"},   int'(pll_req),   0);
        check({ctx, " pll_err"},   int'(pll_err),   0);
        check({ctx, " mode_busy"}, int'(mode_busy), 1);
        check_mode(ctx, 0);
    endtask

    // One clock: advance, then drive the vsync and PLL-completion stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc == vs_cyc)     tg_vs = 1'b0;
        if (cyc == vs_cyc + 4) tg_vs = 1'b1;
        if (pll_req) begin
            nreq++;
            if (pll_delay > 0) done_at = cyc + pll_delay;
        end
        pll_done = (cyc == done_at);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            tick();
            ok = !mode_busy && !mode_ack;
        end
        if (!ok) check("idle wait timeout", 0, 1);
    endtask

    // Releases reset and follows the boot pass (PLL, SETTLE, DONE).
    task automatic boot_seq(input int pll_d);
        int r, rise_c = -1, idle_c = -1, nack = 0, x;
        vs_cyc = -1; done_at = -1; nreq = 0; pll_delay = pll_d;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        r = cyc;
        exp_mode = 0;
        exp_err = 1'b0;
        for (int t = 0; t < 300 && idle_c < 0; t++) begin
            tick();
            if (tg_rst_n && rise_c < 0) rise_c = cyc;
            if (mode_ack) nack++;
            if (!mode_busy) idle_c = cyc;
        end
        x = PLL_EN ? (r + 1) + pll_d + 1 : r;
        check("boot tg_rst_n rise", rise_c, x + SETTLE);
        check("boot busy drop", idle_c, x + SETTLE + 1);
        check("boot no ack", nack, 0);
        check("boot pll_req count", nreq, PLL_EN ? 1 : 0);
        check("boot pll_err", int'(pll_err), 0);
        check_mode("boot", 0);
        $display("boot: release@%0d rise@%0d", r, rise_c);
    endtask

    // One mode request; abort>0 asserts reset that many cycles into SETTLE.
    task automatic run_switch(input logic [1:0] sel, input int vs_d, input int pll_d, input int abort);
        int a, l, x, e_rise, e_ack, fall_c = -1, rise_c = -1, ack_c = -1, nack = 0;
        bit same;
        wait_idle();
        tick();
        mode_req = 1'b1;
        mode_sel = sel;
        a = cyc + 1;
        same = (int'(sel) == exp_mode);
        vs_cyc = (vs_d > 0 && !same) ? a + vs_d : -1;
        pll_delay = pll_d; done_at = -1; nreq = 0;
        l = (vs_cyc >= 0 && vs_cyc + 3 < a + VS_TO) ? vs_cyc + 3 : a + VS_TO;
        x = PLL_EN ? l + 1 + ((pll_d > 0) ? pll_d + 1 : PLL_TO) : l + 1;
        e_rise = x + SETTLE;
        e_ack = same ? a + 1 : e_rise + 1;
        if (abort > 0) begin
            for (int t = 0; t < 400 && cyc < x + abort; t++) tick();
            check("abort in settle tg_rst_n", int'(tg_rst_n), 0);
            #2;
            reset_n = 1'b0;
            #1;
            mode_req = 1'b0;
            check_reset_values("abort reset");
            $display("switch sel=%0d aborted by reset @%0d", sel, cyc);
            boot_seq(pll_d);
            return;
        end
        for (int t = 0; t < 400 && ack_c < 0; t++) begin
            tick();
            if (!tg_rst_n && fall_c < 0) fall_c = cyc;
            if (tg_rst_n && fall_c >= 0 && rise_c < 0) rise_c = cyc;
            if (mode_ack) begin
                nack++;
                ack_c = cyc;
            end
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            mode_req = 1'b0;
            if (mode_ack) nack++;
        end
        tg_vs = 1'b1;
        if (!same) exp_mode = int'(sel);
        if (PLL_EN && !same && pll_d == 0) exp_err = 1'b1;
        check("ack cycle", ack_c, e_ack);
        check("single ack", nack, 1);
        check("tg_rst_n fall", fall_c, same ? -1 : l);
        check("tg_rst_n rise", rise_c, same ? -1 : e_rise);
        check("pll_req count", nreq, (same || !PLL_EN) ? 0 : 1);
        check("pll_err", int'(pll_err), int'(exp_err));
        check("busy after ack", int'(mode_busy), 0);
        check_mode("switch", exp_mode);
        $display("switch sel=%0d vs_d=%0d pll_d=%0d ack@%0d fall@%0d rise@%0d",
                 sel, vs_d, pll_d, ack_c, fall_c, rise_c);
    endtask

    initial begin
        reset_n = 1'b0; mode_req = 1'b0; mode_sel = 2'd0; tg_vs = 1'b1; pll_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        boot_seq(5);
        run_switch(2'd1, 30, 5, 0);   // frame-edge switch to 1280x720
        run_switch(2'd1, 10, 5, 0);   // same mode: immediate ack
        run_switch(2'd3, 0, 7, 0);    // no frame edge: vsync timeout
        run_switch(2'd0, 20, 0, 0);   // PLL never answers: sticky error
        run_switch(2'd2, 15, 4, 0);   // PLL answers, error stays set
        for (int i = 0; i < 12; i++) begin
            run_switch(2'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)),
                       ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15)), 0);
        end
        run_switch(2'd0, 5, 3, 0);
        run_switch(2'd2, 12, 3, 5);   // reset during SETTLE of a switch to mode 2
        run_switch(2'd1, 8, 6, 0);    // normal operation after the reboot
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
